// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and ALU opcode constants for the UART/ALU link
package uart_pkg;
   typedef enum logic [2:0] {
      WAIT_A,
      WAIT_B,
      WAIT_OP,
      CALC,
      SEND,
      WAIT_TX
   } state_t;
   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;
endpackage

// File: rtl/idle_timer.sv
// idle_timer: inter-byte watchdog counter; expire is high in the cycle the count hits TIMEOUT_CYCLES-1
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   restart counting from zero (byte accepted)
//   en     in   count while high; held at zero while low
//   expire out  combinational, high while enabled at the terminal count
module idle_timer #(
   parameter int TIMEOUT_CYCLES = 4000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] cnt;
   assign expire = en && cnt == TW'(TIMEOUT_CYCLES - 1);
   // clearing on expiry means the counter never needs to wrap
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else        cnt <= (en && !clr && !expire) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects A, B, opcode bytes from the UART receiver, drives the ALU and returns a one-byte reply
//   CLK_100MHZ     in   system clock
//   reset          in   asynchronous active-low reset
//   rx_done_tick   in   receiver byte strobe, rx_data valid
//   rx_data        in   received byte
//   tx_done_tick   in   transmitter finished strobe
//   alu_result     in   combinational ALU result
//   alu_a/alu_b    out  registered operands
//   alu_op         out  registered opcode (low OP_BITS of the opcode byte)
//   tx_data        out  reply byte, held until the transmitter finishes
//   tx_start       out  one-cycle transmit request
//   busy           out  high from CALC until tx_done_tick
//   timeout_pulse  out  one-cycle pulse when a partial command is discarded
module uart_alu_interface
   import uart_pkg::*;
#(
   parameter int NBITS          = 8,
   parameter int OP_BITS        = 6,
   parameter int TIMEOUT_CYCLES = 4000000
) (
   input  logic               CLK_100MHZ,
   input  logic               reset,
   input  logic               rx_done_tick,
   input  logic [NBITS-1:0]   rx_data,
   input  logic               tx_done_tick,
   input  logic [NBITS-1:0]   alu_result,
   output logic [NBITS-1:0]   alu_a,
   output logic [NBITS-1:0]   alu_b,
   output logic [OP_BITS-1:0] alu_op,
   output logic [NBITS-1:0]   tx_data,
   output logic               tx_start,
   output logic               busy,
   output logic               timeout_pulse
);
   state_t state, state_nx;
   logic   tmr_en, expire;
   assign tmr_en = state == WAIT_B || state == WAIT_OP;
   idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk    (CLK_100MHZ),
      .rst_n  (reset),
      .clr    (rx_done_tick),
      .en     (tmr_en),
      .expire (expire)
   );
   always_ff @(posedge CLK_100MHZ or negedge reset)
      if (!reset) state <= WAIT_A;
      else        state <= state_nx;
   // outputs decode from state so an asynchronous reset clears them immediately
   always_comb begin
      state_nx      = state;
      tx_start      = state == SEND;
      busy          = state == CALC || state == SEND || state == WAIT_TX;
      timeout_pulse = expire && !rx_done_tick;
      case (state)
         WAIT_A:  state_nx = rx_done_tick ? WAIT_B : WAIT_A;
         WAIT_B:  state_nx = rx_done_tick ? WAIT_OP : expire ? WAIT_A : WAIT_B;
         WAIT_OP: state_nx = rx_done_tick ? CALC : expire ? WAIT_A : WAIT_OP;
         CALC:    state_nx = SEND;
         SEND:    state_nx = WAIT_TX;
         WAIT_TX: state_nx = tx_done_tick ? WAIT_A : WAIT_TX;
         default: state_nx = WAIT_A;
      endcase
   end
   always_ff @(posedge CLK_100MHZ or negedge reset)
      if (!reset) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_op  <= '0;
         tx_data <= '0;
      end else begin
         if (state == WAIT_A && rx_done_tick)  alu_a   <= rx_data;
         if (state == WAIT_B && rx_done_tick)  alu_b   <= rx_data;
         if (state == WAIT_OP && rx_done_tick) alu_op  <= rx_data[OP_BITS-1:0];
         if (state == CALC)                    tx_data <= alu_result;
      end
endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: scoreboard bench with a behavioural ALU and UART tick drivers
module tb_uart_alu_interface;
   import uart_pkg::*;
   logic       clk = 0, rst_n = 0, rx_done_tick = 0, tx_done_tick = 0;
   logic [7:0] rx_data = 0, alu_result, alu_a, alu_b, tx_data;
   logic [5:0] alu_op;
   logic       tx_start, busy, timeout_pulse;
   int         n_vec = 0, n_err = 0, n_tx = 0, n_tmo = 0, n_cmd = 0;
   logic [7:0] exp_q[$];
   always #5 clk = ~clk;
   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NOR:  return ~(a | b);
         OP_SRL:  return a >> b[2:0];
         OP_SRA:  return 8'($signed(a) >>> b[2:0]);
         default: return 8'h00;
      endcase
   endfunction
   assign alu_result = alu_model(alu_a, alu_b, alu_op);
   uart_alu_interface #(.NBITS(8), .OP_BITS(6), .TIMEOUT_CYCLES(100)) dut (
      .CLK_100MHZ    (clk),
      .reset         (rst_n),
      .rx_done_tick  (rx_done_tick),
      .rx_data       (rx_data),
      .tx_done_tick  (tx_done_tick),
      .alu_result    (alu_result),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_op        (alu_op),
      .tx_data       (tx_data),
      .tx_start      (tx_start),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (timeout_pulse) n_tmo++;
      if (tx_start) begin
         n_tx++;
         check("tx_pending", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
   end
   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_done_tick = 1;
      @(posedge clk); #1;
      rx_done_tick = 0;
   endtask
   task automatic do_tail(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      exp_q.push_back(alu_model(a, b, op[5:0]));
      n_cmd++;
      send_byte(op);
      @(negedge clk);
      check("calc_txs", 32'(tx_start), 0);
      check("calc_busy", 32'(busy), 1);
      check("alu_op", 32'(alu_op), 32'(op[5:0]));
      @(negedge clk);
      check("send_txs", 32'(tx_start), 1);
   endtask
   task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      send_byte(a);
      send_byte(b);
      do_tail(a, b, op);
   endtask
   task automatic finish_tx(input logic [7:0] exp);
      repeat (3) @(negedge clk);
      check("wtx_busy", 32'(busy), 1);
      check("wtx_txs", 32'(tx_start), 0);
      check("wtx_data", 32'(tx_data), 32'(exp));
      @(posedge clk); #1 tx_done_tick = 1;
      @(posedge clk); #1 tx_done_tick = 0;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      int tx0, tmo0;
      #12;
      check("rst_a", 32'(alu_a), 0);
      check("rst_b", 32'(alu_b), 0);
      check("rst_op", 32'(alu_op), 0);
      check("rst_txd", 32'(tx_data), 0);
      check("rst_txs", 32'(tx_start), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_tmo", 32'(timeout_pulse), 0);
      @(negedge clk) rst_n = 1;
      // basic add with latency checks
      do_cmd(8'h05, 8'h03, 8'h20);
      check("t1_a", 32'(alu_a), 32'h05);
      check("t1_b", 32'(alu_b), 32'h03);
      finish_tx(8'h08);
      // back-to-back commands
      tx0 = n_tx;
      do_cmd(8'hF0, 8'h0F, 8'h25);
      finish_tx(8'hFF);
      do_cmd(8'h0A, 8'h02, 8'h22);
      finish_tx(8'h08);
      check("t2_pulses", 32'(n_tx - tx0), 2);
      // inter-byte timeout after operand A
      send_byte(8'h11);
      repeat (99) @(negedge clk);
      check("t3_early", 32'(timeout_pulse), 0);
      @(negedge clk);
      check("t3_pulse", 32'(timeout_pulse), 1);
      check("t3_keep_a", 32'(alu_a), 32'h11);
      @(negedge clk);
      check("t3_single", 32'(timeout_pulse), 0);
      check("t3_idle", 32'(busy), 0);
      do_cmd(8'h07, 8'h01, 8'h20);
      finish_tx(8'h08);
      // byte during WAIT_TX is dropped; stray tx_done in idle is ignored
      do_cmd(8'h04, 8'h04, 8'h20);
      send_byte(8'h99);
      check("t4_keep_a", 32'(alu_a), 32'h04);
      check("t4_busy", 32'(busy), 1);
      finish_tx(8'h08);
      @(posedge clk); #1 tx_done_tick = 1;
      @(posedge clk); #1 tx_done_tick = 0;
      do_cmd(8'h01, 8'h01, 8'h20);
      finish_tx(8'h02);
      // upper opcode bits ignored
      do_cmd(8'h03, 8'h04, 8'hE0);
      finish_tx(8'h07);
      // asynchronous reset in WAIT_OP
      send_byte(8'h33);
      send_byte(8'h44);
      @(negedge clk);
      check("t5_pre_a", 32'(alu_a), 32'h33);
      #2 rst_n = 0;
      #1;
      check("t5_a", 32'(alu_a), 0);
      check("t5_b", 32'(alu_b), 0);
      check("t5_op", 32'(alu_op), 0);
      check("t5_txd", 32'(tx_data), 0);
      check("t5_busy", 32'(busy), 0);
      @(negedge clk) rst_n = 1;
      do_cmd(8'h02, 8'h02, 8'h20);
      finish_tx(8'h04);
      // asynchronous reset while tx_start is high
      do_cmd(8'h10, 8'h20, 8'h20);
      #2 rst_n = 0;
      #1;
      check("rs_txs", 32'(tx_start), 0);
      check("rs_busy", 32'(busy), 0);
      check("rs_txd", 32'(tx_data), 0);
      @(negedge clk) rst_n = 1;
      // byte arrives on the exact expiry cycle
      tmo0 = n_tmo;
      send_byte(8'h55);
      repeat (98) @(posedge clk);
      send_byte(8'h66);
      @(negedge clk);
      check("t6_no_pulse", 32'(n_tmo - tmo0), 0);
      check("t6_b", 32'(alu_b), 32'h66);
      check("t6_busy", 32'(busy), 0);
      do_tail(8'h55, 8'h66, 8'h20);
      finish_tx(8'hBB);
      repeat (2) @(negedge clk);
      check("tx_count", 32'(n_tx), 32'(n_cmd));
      check("q_empty", 32'(exp_q.size()), 0);
      check("tmo_count", 32'(n_tmo), 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
